// File: rtl/seven_segment_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// Segment patterns are active-high; polarity is applied only at the output registers.
package seven_segment_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Index is the hex nibble; bit n of each entry drives segment SEG_A + n.
    localparam logic [6:0] HEX_SEGMENTS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int slot_cycles(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] segments, input bit active_low);
        return active_low ? ~segments : segments;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = HEX_SEGMENTS[nibble];

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment scanner: prescaled digit slots, frame-aligned
// double-buffered display data, leading-zero blanking and registered outputs.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int CLK_HZ         = 27_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DIGITS         = 4,
    parameter int BLANK_CYCLES   = 2,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_DIG = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            led,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame
);

    localparam int SLOT  = slot_cycles(CLK_HZ, SCAN_HZ);
    localparam int PRE_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SLOT - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    logic                boundary;

    logic [4*DIGITS-1:0] pending_value;
    logic [DIGITS-1:0]   pending_dp;
    logic [4*DIGITS-1:0] active_value;
    logic [DIGITS-1:0]   active_dp;

    logic [DIGITS-1:0]   blanked;
    logic                upper_zero;
    logic                digit_blank;
    logic [3:0]          nibble;
    logic [6:0]          decoded;

    logic [6:0]          seg_next;
    logic                dp_next;
    logic [DIGITS-1:0]   en_next;

    assign tick     = enable && (pre == PRE_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
            idx <= '0;
        end else if (!enable) begin
            pre <= '0;
            idx <= '0;
        end else if (tick) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // While scanning is stopped every cycle acts as a frame boundary, so the
    // first frame after enable already shows the latest load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_value <= '0;
            pending_dp    <= '0;
            active_value  <= '0;
            active_dp     <= '0;
        end else begin
            if (load) begin
                pending_value <= value;
                pending_dp    <= dp_in;
            end
            if (!enable || boundary) begin
                active_value <= load ? value : pending_value;
                active_dp    <= load ? dp_in : pending_dp;
            end
        end
    end

    // A digit is blanked when it and every more significant nibble are zero
    // and it carries no decimal point; digit 0 always shows.
    always_comb begin
        blanked    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (active_value[4*i +: 4] == 4'h0);
            blanked[i] = blank_lz & upper_zero & ~active_dp[i];
        end
    end

    assign nibble      = 4'(active_value >> {idx, 2'b00});
    assign digit_blank = blanked[idx];

    seg7_decode u_decode (
        .nibble   (nibble),
        .segments (decoded)
    );

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        en_next  = '0;
        if (enable && !digit_blank) begin
            seg_next = decoded;
            dp_next  = active_dp[idx];
            if (pre >= PRE_BLANK) begin
                en_next = DIGITS'(1) << idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led      <= seg_polarity(SEG_OFF, ACTIVE_LOW_SEG);
            dp       <= ACTIVE_LOW_SEG;
            digit_en <= {DIGITS{ACTIVE_LOW_DIG}};
            frame    <= 1'b0;
        end else begin
            led      <= seg_polarity(seg_next, ACTIVE_LOW_SEG);
            dp       <= dp_next ^ ACTIVE_LOW_SEG;
            digit_en <= en_next ^ {DIGITS{ACTIVE_LOW_DIG}};
            frame    <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: slot/frame-position reference model checked every
// cycle, literal pins for the documented scenarios, then randomized traffic.
module tb_seven_segment_scan;

    localparam int CLK_HZ = 1000;
    localparam int SCAN_HZ = 250;
    localparam int NDIG = 4;
    localparam int BLANK = 1;
    localparam int SLOT = CLK_HZ / SCAN_HZ;
    localparam int FRAME_LEN = NDIG * SLOT;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  led;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame;

    int checks = 0;
    int failures = 0;

    seven_segment_scan #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(NDIG), .BLANK_CYCLES(BLANK),
        .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_DIG(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .load(load),
        .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .led(led), .dp(dp), .digit_en(digit_en), .frame(frame)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Reference model: position t within the frame, a pending word and the word
    // latched for the current frame. Expected outputs follow the state by a cycle.
    int          t = 0;
    logic [15:0] m_pend = '0, m_act = '0;
    logic [3:0]  m_pend_dp = '0, m_act_dp = '0;
    logic [6:0]  exp_led = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [3:0]  exp_en = 4'hF;
    logic        exp_frame = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        int p, d;
        logic blk;
        if (!reset_n) begin
            t = 0; m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0;
            exp_led = 7'h7F; exp_dp = 1'b1; exp_en = 4'hF; exp_frame = 1'b0;
        end else begin
            p = t % SLOT;
            d = t / SLOT;
            blk = blank_lz && d >= 1 && ((m_act >> (4 * d)) == 16'h0) && !m_act_dp[d];
            if (!enable) begin
                exp_led = 7'h7F; exp_dp = 1'b1; exp_en = 4'hF; exp_frame = 1'b0;
            end else begin
                exp_led   = blk ? 7'h7F : ~hex_seg(4'(m_act >> (4 * d)));
                exp_dp    = !(!blk && m_act_dp[d]);
                exp_en    = (p >= BLANK && !blk) ? ~(4'b0001 << d) : 4'hF;
                exp_frame = (t == FRAME_LEN - 1);
            end
            if (!enable || t == FRAME_LEN - 1) begin
                m_act    = load ? value : m_pend;
                m_act_dp = load ? dp_in : m_pend_dp;
            end
            if (load) begin
                m_pend = value;
                m_pend_dp = dp_in;
            end
            t = enable ? (t + 1) % FRAME_LEN : 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic step();
        @(negedge clock);
        check("model led", 32'(led), 32'(exp_led));
        check("model dp", 32'(dp), 32'(exp_dp));
        check("model digit_en", 32'(digit_en), 32'(exp_en));
        check("model frame", 32'(frame), 32'(exp_frame));
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (frame !== 1'b1 && n < 64);
        check("frame seen", 32'(frame), 32'd1);
    endtask

    initial begin
        int n;
        logic [15:0] mask;

        repeat (3) step();
        check("reset led", 32'(led), 32'h7F);
        check("reset dp", 32'(dp), 32'h1);
        check("reset digit_en", 32'(digit_en), 32'hF);
        check("reset frame", 32'(frame), 32'h0);
        reset_n = 1'b1;
        repeat (2) step();
        check("idle led", 32'(led), 32'h7F);
        check("idle digit_en", 32'(digit_en), 32'hF);

        // Basic scan of 12AF
        value = 16'h12AF; dp_in = 4'h0; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        for (int k = 1; k <= FRAME_LEN; k++) begin
            step();
            case (k)
                1:  begin check("scan d0 blank en", 32'(digit_en), 32'hF); check("scan d0 led", 32'(led), 32'h0E); end
                2:  begin check("scan d0 en", 32'(digit_en), 32'hE); check("scan d0 dp", 32'(dp), 32'h1); end
                6:  begin check("scan d1 led", 32'(led), 32'h08); check("scan d1 en", 32'(digit_en), 32'hD); end
                8:  check("scan no frame", 32'(frame), 32'h0);
                10: begin check("scan d2 led", 32'(led), 32'h24); check("scan d2 en", 32'(digit_en), 32'hB); end
                14: begin check("scan d3 led", 32'(led), 32'h79); check("scan d3 en", 32'(digit_en), 32'h7); end
                16: check("scan frame", 32'(frame), 32'h1);
                default: ;
            endcase
        end
        wait_frame(n);
        check("frame period", 32'(n), 32'(FRAME_LEN));

        // Leading-zero blanking on 0050
        blank_lz = 1'b1; value = 16'h0050; load = 1'b1;
        step();
        load = 1'b0;
        wait_frame(n);
        for (int k = 1; k <= FRAME_LEN; k++) begin
            step();
            case (k)
                2:  begin check("lz d0 led", 32'(led), 32'h40); check("lz d0 en", 32'(digit_en), 32'hE); end
                6:  begin check("lz d1 led", 32'(led), 32'h12); check("lz d1 en", 32'(digit_en), 32'hD); end
                10: begin check("lz d2 led", 32'(led), 32'h7F); check("lz d2 en", 32'(digit_en), 32'hF); end
                14: begin check("lz d3 led", 32'(led), 32'h7F); check("lz d3 en", 32'(digit_en), 32'hF); end
                default: ;
            endcase
        end
        dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        wait_frame(n);
        for (int k = 1; k <= FRAME_LEN; k++) begin
            step();
            case (k)
                10: begin
                    check("lz dp d2 led", 32'(led), 32'h40);
                    check("lz dp d2 dp", 32'(dp), 32'h0);
                    check("lz dp d2 en", 32'(digit_en), 32'hB);
                end
                14: check("lz dp d3 en", 32'(digit_en), 32'hF);
                default: ;
            endcase
        end

        // Tear-free update, then a load on the boundary cycle itself
        blank_lz = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            step();
            case (k)
                5:  begin value = 16'h1111; dp_in = 4'h0; load = 1'b1; end
                6:  load = 1'b0;
                13: begin value = 16'h2222; load = 1'b1; end
                14: begin load = 1'b0; check("tear old frame", 32'(led), 32'h40); end
                16: check("tear frame", 32'(frame), 32'h1);
                18: check("tear new d0", 32'(led), 32'h24);
                26: check("tear new d2", 32'(led), 32'h24);
                31: begin value = 16'h0789; load = 1'b1; end
                32: begin load = 1'b0; check("edge frame", 32'(frame), 32'h1); check("edge old d3", 32'(led), 32'h24); end
                33: begin check("edge new d0", 32'(led), 32'h10); check("edge blank", 32'(digit_en), 32'hF); end
                default: ;
            endcase
        end

        // Drop enable inside digit 2's slot, then resume
        repeat (9) step();
        enable = 1'b0;
        step();
        check("disable led", 32'(led), 32'h7F);
        check("disable en", 32'(digit_en), 32'hF);
        check("disable frame", 32'(frame), 32'h0);
        repeat (20) step();
        enable = 1'b1;
        step();
        check("resume d0 led", 32'(led), 32'h10);
        check("resume blank", 32'(digit_en), 32'hF);
        step();
        check("resume d0 en", 32'(digit_en), 32'hE);

        // Asynchronous reset in the middle of a slot
        repeat (5) step();
        #3 reset_n = 1'b0;
        #1;
        check("async led", 32'(led), 32'h7F);
        check("async dp", 32'(dp), 32'h1);
        check("async en", 32'(digit_en), 32'hF);
        check("async frame", 32'(frame), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        check("post reset d0 led", 32'(led), 32'h40);
        check("post reset blank", 32'(digit_en), 32'hF);
        step();
        check("post reset en", 32'(digit_en), 32'hE);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h00FF;
                2: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom) & mask;
            dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 15) == 0) enable = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
